l2_cache: RTL and testbench

//  Unified set-associative, write-back, write-allocate L2 cache between L1_cache and main memory.

---
 rtl/l2_cache.sv | 216 +++++++++++++++++++++
 tb/tb_l2_cache.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache.sv
// Set-associative write-back/write-allocate L2 with round-robin replacement, one request in flight.
// Optional hit/miss counters are built when L2_STATS_EN is defined.
`timescale 1ns/1ps

module l2_way_cmp #(
   parameter int TAG_W = 22
) (
   input  logic             vld,
   input  logic [TAG_W-1:0] way_tag,
   input  logic [TAG_W-1:0] req_tag,
   output logic             hit
);
   assign hit = vld && (way_tag == req_tag);
endmodule

module l2_cache #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int CACHE_SIZE = 4096,
   parameter int BLOCK_SIZE = 16,
   parameter int NUM_WAYS   = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [ADDR_WIDTH-1:0]                 l1_addr,
   input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l1_data_in,
   output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l1_data_out,
   input  logic                                  l1_read,
   input  logic                                  l1_write,
   output logic                                  l1_ready,
   output logic                                  l1_hit,
   output logic [ADDR_WIDTH-1:0]                 mem_addr,
   output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out,
   input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_in,
   output logic                                  mem_read,
   output logic                                  mem_write,
   input  logic                                  mem_ready,
   output logic [31:0]                           stat_hits,
   output logic [31:0]                           stat_misses
);
   localparam int OFF_W    = $clog2(BLOCK_SIZE);
   localparam int NUM_SETS = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
   localparam int IDX_W    = $clog2(NUM_SETS);
   localparam int TAG_W    = ADDR_WIDTH - IDX_W - OFF_W;
   localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

   typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] line_t;
   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_FILL, S_RESPOND} state_t;

   state_t                             state_q, state_d;
   logic [TAG_W-1:0]                   req_tag_q;
   logic [IDX_W-1:0]                   req_idx_q;
   logic                               req_wr_q;
   line_t                              req_line_q;
   logic [WAY_W-1:0]                   vict_q;

   line_t                              data_q [NUM_SETS][NUM_WAYS];
   logic [TAG_W-1:0]                   tag_q  [NUM_SETS][NUM_WAYS];
   logic [NUM_SETS-1:0][NUM_WAYS-1:0]  valid_q, dirty_q;
   logic [NUM_SETS-1:0][WAY_W-1:0]     rr_q;

   logic [NUM_WAYS-1:0]                hit_vec;
   logic                               hit, has_inv, vict_dirty;
   logic [WAY_W-1:0]                   hit_way, inv_way, vict_way;
   logic                               unused_off;

   assign unused_off = ^l1_addr[OFF_W-1:0];

   for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      l2_way_cmp #(.TAG_W(TAG_W)) u_cmp (
         .vld     (valid_q[req_idx_q][w]),
         .way_tag (tag_q[req_idx_q][w]),
         .req_tag (req_tag_q),
         .hit     (hit_vec[w])
      );
   end

   // Descending scan so the lowest-index match / invalid way wins.
   always_comb begin
      hit_way = '0;
      inv_way = '0;
      has_inv = 1'b0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (hit_vec[w]) hit_way = WAY_W'(w);
         if (!valid_q[req_idx_q][w]) begin
            inv_way = WAY_W'(w);
            has_inv = 1'b1;
         end
      end
      hit        = |hit_vec;
      vict_way   = has_inv ? inv_way : rr_q[req_idx_q];
      vict_dirty = valid_q[req_idx_q][vict_way] && dirty_q[req_idx_q][vict_way];
   end

   // Memory strobes decode straight from state so reset drops them asynchronously.
   always_comb begin
      state_d      = state_q;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_addr     = '0;
      mem_data_out = '0;
      l1_ready     = 1'b0;
      case (state_q)
         S_IDLE:      if (l1_read || l1_write) state_d = S_LOOKUP;
         S_LOOKUP: begin
            if (hit)             state_d = S_RESPOND;
            else if (vict_dirty) state_d = S_WRITEBACK;
            else if (req_wr_q)   state_d = S_RESPOND;
            else                 state_d = S_FILL;
         end
         S_WRITEBACK: begin
            mem_write    = 1'b1;
            mem_addr     = {tag_q[req_idx_q][vict_q], req_idx_q, {OFF_W{1'b0}}};
            mem_data_out = data_q[req_idx_q][vict_q];
            if (mem_ready) state_d = req_wr_q ? S_RESPOND : S_FILL;
         end
         S_FILL: begin
            mem_read = 1'b1;
            mem_addr = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
            if (mem_ready) state_d = S_RESPOND;
         end
         S_RESPOND: begin
            l1_ready = 1'b1;
            state_d  = S_IDLE;
         end
         default:     state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         req_tag_q   <= '0;
         req_idx_q   <= '0;
         req_wr_q    <= 1'b0;
         req_line_q  <= '0;
         vict_q      <= '0;
         valid_q     <= '0;
         dirty_q     <= '0;
         rr_q        <= '0;
         l1_data_out <= '0;
         l1_hit      <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: if (l1_read || l1_write) begin
               req_tag_q  <= l1_addr[ADDR_WIDTH-1 -: TAG_W];
               req_idx_q  <= l1_addr[OFF_W +: IDX_W];
               req_wr_q   <= l1_write;
               req_line_q <= l1_data_in;
            end
            S_LOOKUP: begin
               l1_hit <= hit;
               vict_q <= vict_way;
               if (hit) begin
                  if (req_wr_q) dirty_q[req_idx_q][hit_way] <= 1'b1;
                  else          l1_data_out <= data_q[req_idx_q][hit_way];
               end else begin
                  if (!has_inv)
                     rr_q[req_idx_q] <= (rr_q[req_idx_q] == WAY_W'(NUM_WAYS - 1)) ? '0
                                        : rr_q[req_idx_q] + 1'b1;
                  // Clean write miss installs immediately: the whole line is supplied.
                  if (req_wr_q && !vict_dirty) begin
                     valid_q[req_idx_q][vict_way] <= 1'b1;
                     dirty_q[req_idx_q][vict_way] <= 1'b1;
                  end
               end
            end
            S_WRITEBACK: if (mem_ready) begin
               dirty_q[req_idx_q][vict_q] <= req_wr_q;
               if (req_wr_q) valid_q[req_idx_q][vict_q] <= 1'b1;
            end
            S_FILL: if (mem_ready) begin
               valid_q[req_idx_q][vict_q] <= 1'b1;
               dirty_q[req_idx_q][vict_q] <= 1'b0;
               l1_data_out                <= mem_data_in;
            end
            default: ;
         endcase
      end
   end

   // Line/tag storage is not reset; valid bits gate every use.
   always_ff @(posedge clk) begin
      if (state_q == S_LOOKUP && hit && req_wr_q) begin
         data_q[req_idx_q][hit_way] <= req_line_q;
      end else if (state_q == S_LOOKUP && !hit && req_wr_q && !vict_dirty) begin
         data_q[req_idx_q][vict_way] <= req_line_q;
         tag_q[req_idx_q][vict_way]  <= req_tag_q;
      end else if (state_q == S_WRITEBACK && mem_ready && req_wr_q) begin
         data_q[req_idx_q][vict_q] <= req_line_q;
         tag_q[req_idx_q][vict_q]  <= req_tag_q;
      end else if (state_q == S_FILL && mem_ready) begin
         data_q[req_idx_q][vict_q] <= mem_data_in;
         tag_q[req_idx_q][vict_q]  <= req_tag_q;
      end
   end

`ifdef L2_STATS_EN
   logic [31:0] hits_q, misses_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else if (state_q == S_LOOKUP) begin
         if (hit && hits_q != 32'hFFFF_FFFF)         hits_q   <= hits_q + 32'd1;
         else if (!hit && misses_q != 32'hFFFF_FFFF) misses_q <= misses_q + 32'd1;
      end
   end
   assign stat_hits   = hits_q;
   assign stat_misses = misses_q;
`else
   assign stat_hits   = '0;
   assign stat_misses = '0;
`endif
endmodule

// File: tb/tb_l2_cache.sv
// Directed bench for l2_cache: memory responder with transaction log, scenario tasks.
`timescale 1ns/1ps

module tb_l2_cache;
   typedef logic [15:0][31:0] line_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] l1_addr;
   line_t       l1_data_in, l1_data_out, mem_data_out, mem_data_in;
   logic        l1_read, l1_write, l1_ready, l1_hit;
   logic [31:0] mem_addr;
   logic        mem_read, mem_write, mem_ready;
   logic [31:0] stat_hits, stat_misses;

   int checks = 0;
   int errors = 0;

`ifdef L2_STATS_EN
   localparam logic [31:0] EXP_STAT = 32'd1;
`else
   localparam logic [31:0] EXP_STAT = 32'd0;
`endif

   always #5 clk = ~clk;

   l2_cache dut (
      .clk(clk), .rst_n(rst_n),
      .l1_addr(l1_addr), .l1_data_in(l1_data_in), .l1_data_out(l1_data_out),
      .l1_read(l1_read), .l1_write(l1_write), .l1_ready(l1_ready), .l1_hit(l1_hit),
      .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
      .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
      .stat_hits(stat_hits), .stat_misses(stat_misses)
   );

   function automatic line_t pat(input logic [31:0] a);
      line_t p;
      for (int w = 0; w < 16; w++) p[w] = 32'hD000_0000 ^ (a + 32'(w));
      return p;
   endfunction

   function automatic line_t fill_line(input logic [31:0] v);
      line_t p;
      for (int w = 0; w < 16; w++) p[w] = v;
      return p;
   endfunction

   // Memory model: completes each access on its 2nd cycle, logs it.
   int          wait_cnt = 0;
   int          n_log = 0;
   logic        log_wr   [64];
   logic [31:0] log_addr [64];
   line_t       log_data [64];
   int          bad_bus = 0;

   initial begin
      mem_ready   = 1'b0;
      mem_data_in = '0;
      forever begin
         @(negedge clk);
         mem_ready = 1'b0;
         if (rst_n && (mem_read || mem_write)) begin
            if (mem_read) mem_data_in = pat(mem_addr);
            wait_cnt++;
            if (wait_cnt == 2) begin
               mem_ready = 1'b1;
               wait_cnt  = 0;
               if (n_log < 64) begin
                  log_wr[n_log]   = mem_write;
                  log_addr[n_log] = mem_addr;
                  log_data[n_log] = mem_data_out;
                  n_log++;
               end
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   always @(posedge clk) begin
      if ((mem_read && mem_write) || (l1_ready && (mem_read || mem_write)))
         bad_bus <= bad_bus + 1;
   end

   task automatic do_req(input logic wr, input logic [31:0] a, input line_t d,
                         output logic hit, output line_t q, output int lat);
      @(negedge clk);
      l1_addr = a; l1_data_in = d; l1_write = wr; l1_read = !wr;
      lat = 0; hit = 1'b0; q = '0;
      while (lat < 60) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) begin
            l1_addr    = a ^ 32'hFFFF_FFF0;
            l1_data_in = ~d;
         end
         if (l1_ready) break;
      end
      if (!l1_ready) begin
         checks++; errors++;
         $display("FAIL req_timeout addr=%h got no l1_ready, wanted one within 60 cycles", a);
         lat = -1;
      end else begin
         hit = l1_hit;
         q   = l1_data_out;
      end
      l1_read = 1'b0; l1_write = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (l1_ready !== 1'b0) begin
         errors++; $display("FAIL ready_pulse addr=%h l1_ready=%b wanted 0", a, l1_ready);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; l1_addr = '0; l1_data_in = '0; l1_read = 1'b0; l1_write = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({l1_ready, l1_hit, mem_read, mem_write} !== 4'b0000) begin
         errors++; $display("FAIL reset_strobes got %b wanted 0000", {l1_ready, l1_hit, mem_read, mem_write});
      end
      checks++;
      if (mem_addr !== 32'h0 || l1_data_out !== '0 || mem_data_out !== '0) begin
         errors++; $display("FAIL reset_data mem_addr=%h l1_out0=%h mem_out0=%h wanted 0", mem_addr, l1_data_out[0], mem_data_out[0]);
      end
      checks++;
      if (stat_hits !== 32'h0 || stat_misses !== 32'h0) begin
         errors++; $display("FAIL reset_stats got %0d/%0d wanted 0/0", stat_hits, stat_misses);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_cold_and_hit;
      logic h; line_t q; int lat; int n0;
      n0 = n_log;
      do_req(1'b0, 32'h0000_1000, '0, h, q, lat);
      checks++;
      if (h !== 1'b0) begin errors++; $display("FAIL cold_hit got %b wanted 0", h); end
      checks++;
      if (q !== pat(32'h1000)) begin errors++; $display("FAIL cold_data got %h wanted %h", q[0], pat(32'h1000) ); end
      checks++;
      if (n_log != n0 + 1 || log_wr[n0] !== 1'b0 || log_addr[n0] !== 32'h1000) begin
         errors++; $display("FAIL cold_mem n=%0d wr=%b addr=%h wanted 1 read at 00001000", n_log - n0, log_wr[n0], log_addr[n0]);
      end
      n0 = n_log;
      do_req(1'b0, 32'h0000_100C, '0, h, q, lat);
      checks++;
      if (h !== 1'b1 || lat != 2) begin errors++; $display("FAIL rehit hit=%b lat=%0d wanted 1/2", h, lat); end
      checks++;
      if (q !== pat(32'h1000)) begin errors++; $display("FAIL rehit_data got %h wanted %h", q[0], pat(32'h1000)); end
      checks++;
      if (n_log != n0) begin errors++; $display("FAIL rehit_mem got %0d accesses wanted 0", n_log - n0); end
   endtask

   task automatic test_writeback;
      logic h; line_t q; int lat; int n0;
      logic [31:0] rd_addr [5] = '{32'h1400, 32'h1800, 32'h1C00, 32'h2000, 32'h2400};
      do_req(1'b1, 32'h0000_1000, fill_line(32'hAAAA_AAAA), h, q, lat);
      checks++;
      if (h !== 1'b1 || lat != 2) begin errors++; $display("FAIL wr_hit hit=%b lat=%0d wanted 1/2", h, lat); end
      n0 = n_log;
      for (int i = 0; i < 5; i++) begin
         do_req(1'b0, rd_addr[i], '0, h, q, lat);
         checks++;
         if (h !== 1'b0 || q !== pat(rd_addr[i])) begin
            errors++; $display("FAIL evict_fill addr=%h hit=%b data=%h wanted 0/%h", rd_addr[i], h, q[0], pat(rd_addr[i]));
         end
      end
      checks++;
      if (n_log != n0 + 6) begin errors++; $display("FAIL evict_count got %0d wanted 6", n_log - n0); end
      checks++;
      if (log_wr[n0+3] !== 1'b1 || log_addr[n0+3] !== 32'h1000 || log_data[n0+3] !== fill_line(32'hAAAA_AAAA)) begin
         errors++; $display("FAIL evict_wb wr=%b addr=%h data=%h wanted 1/00001000/aaaaaaaa", log_wr[n0+3], log_addr[n0+3], log_data[n0+3][0]);
      end
      checks++;
      if (log_wr[n0+4] !== 1'b0 || log_addr[n0+4] !== 32'h2000 || log_wr[n0+5] !== 1'b0) begin
         errors++; $display("FAIL evict_order wr=%b addr=%h wanted 0/00002000 after writeback", log_wr[n0+4], log_addr[n0+4]);
      end
   endtask

   task automatic test_round_robin;
      logic h; line_t q; int lat; int n0; int nwr;
      logic [31:0] seq [7] = '{32'h0010, 32'h0410, 32'h0810, 32'h0C10, 32'h1010, 32'h1410, 32'h1810};
      logic [31:0] keep [4] = '{32'h1010, 32'h1410, 32'h1810, 32'h0C10};
      n0 = n_log;
      for (int i = 0; i < 7; i++) do_req(1'b0, seq[i], '0, h, q, lat);
      nwr = 0;
      for (int i = n0; i < n_log; i++) if (log_wr[i]) nwr++;
      checks++;
      if (nwr != 0 || n_log != n0 + 7) begin errors++; $display("FAIL rr_mem writes=%0d reads=%0d wanted 0/7", nwr, n_log - n0); end
      for (int i = 0; i < 4; i++) begin
         do_req(1'b0, keep[i], '0, h, q, lat);
         checks++;
         if (h !== 1'b1 || q !== pat(keep[i])) begin
            errors++; $display("FAIL rr_keep addr=%h hit=%b wanted 1", keep[i], h);
         end
      end
      do_req(1'b0, 32'h0810, '0, h, q, lat);
      checks++;
      if (h !== 1'b0) begin errors++; $display("FAIL rr_evicted addr=00000810 hit=%b wanted 0", h); end
   endtask

   task automatic test_write_miss;
      logic h; line_t q; int lat; int n0; line_t d;
      for (int w = 0; w < 16; w++) d[w] = 32'hBBBB_0000 + 32'(w);
      n0 = n_log;
      do_req(1'b1, 32'h0000_0020, d, h, q, lat);
      checks++;
      if (h !== 1'b0 || n_log != n0) begin errors++; $display("FAIL wmiss hit=%b mem=%0d wanted 0/0", h, n_log - n0); end
      do_req(1'b0, 32'h0000_0028, '0, h, q, lat);
      checks++;
      if (h !== 1'b1 || q !== d || n_log != n0) begin
         errors++; $display("FAIL wmiss_read hit=%b data=%h mem=%0d wanted 1/%h/0", h, q[0], n_log - n0, d[0]);
      end
   endtask

   task automatic test_reset_mid_fill;
      logic h; line_t q; int lat; int n;
      @(negedge clk);
      l1_addr = 32'h0000_3030; l1_read = 1'b1;
      n = 0;
      while (!mem_read && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (mem_read !== 1'b1) begin errors++; $display("FAIL midfill_start mem_read=%b wanted 1", mem_read); end
      rst_n = 1'b0; #1;
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL midfill_drop mem_read=%b wanted 0", mem_read); end
      l1_read = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      do_req(1'b0, 32'h0000_3030, '0, h, q, lat);
      checks++;
      if (h !== 1'b0 || q !== pat(32'h3030)) begin errors++; $display("FAIL post_reset_read hit=%b wanted 0", h); end
      do_req(1'b0, 32'h0000_3034, '0, h, q, lat);
      checks++;
      if (h !== 1'b1) begin errors++; $display("FAIL post_reset_hit hit=%b wanted 1", h); end
      checks++;
      if (stat_hits !== EXP_STAT || stat_misses !== EXP_STAT) begin
         errors++; $display("FAIL stats hits=%0d misses=%0d wanted %0d/%0d", stat_hits, stat_misses, EXP_STAT, EXP_STAT);
      end
   endtask

   initial begin
      test_reset;
      test_cold_and_hit;
      test_writeback;
      test_round_robin;
      test_write_miss;
      test_reset_mid_fill;
      checks++;
      if (bad_bus != 0) begin errors++; $display("FAIL bus_rules violations=%0d wanted 0", bad_bus); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
